// File: rtl/vpi_value_change_log.sv
// Multi-channel value-change recorder: masked changes become {channel, value, timestamp}
// records, coalesced per channel and queued in a first-word fall-through FIFO.
module vpi_value_change_log #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CH_W-1:0]          rd_ch,
  output logic [DATA_W-1:0]        rd_value,
  output logic [TS_W-1:0]          rd_time,
  output logic [CNT_W-1:0]         count,
  output logic                     dropped
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_prev      [NUM_CH];
  logic [DATA_W-1:0] r_pend_val  [NUM_CH];
  logic [TS_W-1:0]   r_pend_time [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [TS_W-1:0]   r_ts;
  logic [CH_W-1:0]   r_mem_ch    [DEPTH];
  logic [DATA_W-1:0] r_mem_val   [DEPTH];
  logic [TS_W-1:0]   r_mem_time  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic              r_dropped;

  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic [CH_W-1:0]   w_push_ch;
  logic              w_arm;
  logic              w_run;
  logic [NUM_CH-1:0] w_change;
  logic [CNT_W-1:0]  w_count_nxt;

  // Scheduler, change detection and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_push_ch   = '0;
    w_change    = '0;
    w_count_nxt = r_count;
    w_pop       = rd_ready && (r_count != '0);
    w_full      = (r_count == CNT_W'(DEPTH));
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_pending[c]) w_push_ch = CH_W'(c);
    end
    w_push = (|r_pending) && (!w_full || w_pop);
    w_arm  = enable && (r_state != S_RUN);
    w_run  = enable && (r_state == S_RUN);
    for (int c = 0; c < NUM_CH; c++) begin
      w_change[c] = w_run && ch_mask[c] && (ch_data[c*DATA_W +: DATA_W] != r_prev[c]);
    end
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
    if (clear)       w_state_nxt = enable ? S_ARM : S_IDLE;
    else if (enable) w_state_nxt = S_RUN;
    else             w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_ts      <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_prev[c]      <= '0;
        r_pend_val[c]  <= '0;
        r_pend_time[c] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ch[i]   <= '0;
        r_mem_val[i]  <= '0;
        r_mem_time[i] <= '0;
      end
    end else if (clear) begin
      r_pending <= '0;
      r_ts      <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      if (w_arm) begin
        for (int c = 0; c < NUM_CH; c++) r_prev[c] <= ch_data[c*DATA_W +: DATA_W];
      end
      // Clear the pushed bit first so a same-edge change on that channel re-arms it
      if (w_push) r_pending[w_push_ch] <= 1'b0;
      if (w_run) begin
        r_ts <= r_ts + TS_W'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          r_prev[c] <= ch_data[c*DATA_W +: DATA_W];
          if (w_change[c]) begin
            r_pending[c]   <= 1'b1;
            r_pend_val[c]  <= ch_data[c*DATA_W +: DATA_W];
            r_pend_time[c] <= r_ts;
            if (r_pending[c] && !(w_push && (w_push_ch == CH_W'(c)))) r_dropped <= 1'b1;
          end
        end
      end
      if (w_push) begin
        r_mem_ch[r_wr_ptr]   <= w_push_ch;
        r_mem_val[r_wr_ptr]  <= r_pend_val[w_push_ch];
        r_mem_time[r_wr_ptr] <= r_pend_time[w_push_ch];
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign rd_valid = r_valid;
  assign rd_ch    = r_mem_ch[r_rd_ptr];
  assign rd_value = r_mem_val[r_rd_ptr];
  assign rd_time  = r_mem_time[r_rd_ptr];
  assign count    = r_count;
  assign dropped  = r_dropped;

endmodule

// File: tb/tb_vpi_value_change_log.sv
// Bench for vpi_value_change_log: directed scenarios plus randomized traffic
// compared against a queue-based record model.
module tb_vpi_value_change_log;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [3:0]  ch_mask;
  logic [31:0] ch_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  rd_ch;
  logic [7:0]  rd_value;
  logic [15:0] rd_time;
  logic [4:0]  count;
  logic        dropped;

  int n_tests = 0;
  int n_fail  = 0;

  vpi_value_change_log #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .ch_mask(ch_mask),
    .ch_data(ch_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch),
    .rd_value(rd_value), .rd_time(rd_time), .count(count), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Reference model: records as a queue, per-channel pending slots, run/armed flags
  typedef struct { int ch; int val; int t; } rec_t;
  rec_t m_q[$];
  bit   m_running;
  int   m_prev[NUM_CH];
  int   m_pval[NUM_CH];
  int   m_ptime[NUM_CH];
  bit   m_pend[NUM_CH];
  int   m_ts;
  bit   m_drop;

  function automatic int chv(input int c);
    logic [31:0] t;
    t = ch_data >> (c * 8);
    return int'(t[7:0]);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_running = 0;
    m_ts = 0;
    m_drop = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_prev[c] = 0; m_pval[c] = 0; m_ptime[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_step();
    bit pop;
    bit can_push;
    int pc;
    int v;
    pop = rd_ready && (m_q.size() > 0);
    if (clear) begin
      m_q.delete();
      for (int c = 0; c < NUM_CH; c++) m_pend[c] = 0;
      m_drop = 0;
      m_ts = 0;
      m_running = 0;
      return;
    end
    pc = -1;
    for (int c = 0; c < NUM_CH; c++) if (m_pend[c] && pc < 0) pc = c;
    can_push = (pc >= 0) && (m_q.size() < DEPTH || pop);
    if (pop) m_q.delete(0);
    if (can_push) begin
      m_q.push_back('{ch: pc, val: m_pval[pc], t: m_ptime[pc]});
      m_pend[pc] = 0;
    end
    if (!enable) begin
      m_running = 0;
    end else if (!m_running) begin
      for (int c = 0; c < NUM_CH; c++) m_prev[c] = chv(c);
      m_running = 1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        v = chv(c);
        if (ch_mask[c] && v != m_prev[c]) begin
          if (m_pend[c]) m_drop = 1;
          m_pend[c] = 1;
          m_pval[c] = v;
          m_ptime[c] = m_ts;
        end
        m_prev[c] = v;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    ch_data[c*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    ch_mask = 4'hF; ch_data = 32'h0;
    model_reset();
    #12;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b exp 0", dropped); end
    n_tests++; if (rd_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", rd_ch); end
    n_tests++; if (rd_value !== 8'd0) begin n_fail++; $display("FAIL reset_value got %h exp 00", rd_value); end
    n_tests++; if (rd_time !== 16'd0) begin n_fail++; $display("FAIL reset_time got %0d exp 0", rd_time); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arm_latency();
    enable = 1'b1;
    tick();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL arm_no_record count got %0d exp 0", count); end
    repeat (3) tick();
    set_ch(1, 8'h5A);
    tick();
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early valid got %b exp 0", rd_valid); end
    tick();
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b exp 1", rd_valid); end
    n_tests++; if (rd_ch !== 2'd1) begin n_fail++; $display("FAIL latency_ch got %0d exp 1", rd_ch); end
    n_tests++; if (rd_value !== 8'h5A) begin n_fail++; $display("FAIL latency_value got %h exp 5a", rd_value); end
    n_tests++; if (rd_time !== 16'd3) begin n_fail++; $display("FAIL latency_time got %0d exp 3", rd_time); end
  endtask

  task automatic test_simultaneous();
    int peak;
    int exp_ch[3];
    int exp_val[3];
    exp_ch = '{0, 2, 3};
    exp_val = '{8'h11, 8'h22, 8'h33};
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    set_ch(0, 8'h11); set_ch(2, 8'h22); set_ch(3, 8'h33);
    peak = 0;
    repeat (5) begin
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    n_tests++; if (peak != 3) begin n_fail++; $display("FAIL simul_peak got %0d exp 3", peak); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rd_valid !== 1'b1 || int'(rd_ch) != exp_ch[i] || int'(rd_value) != exp_val[i] || rd_time !== 16'd6) begin
        n_fail++;
        $display("FAIL simul_rec%0d got v=%b ch=%0d val=%h t=%0d exp ch=%0d val=%h t=6",
                 i, rd_valid, rd_ch, rd_value, rd_time, exp_ch[i], exp_val[i]);
      end
      tick();
    end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL simul_drained count got %0d exp 0", count); end
  endtask

  task automatic test_coalesce();
    int seen1;
    int val1;
    int budget;
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_ch(3, 8'(8'h40 + i));
      tick();
    end
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL coal_full count got %0d exp 16", count); end
    set_ch(1, 8'h01);
    tick();
    n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL coal_first dropped got %b exp 0", dropped); end
    set_ch(1, 8'h02);
    tick();
    n_tests++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL coal_drop dropped got %b exp 1", dropped); end
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL coal_backpressure count got %0d exp 16", count); end
    rd_ready = 1'b1;
    seen1 = 0; val1 = -1; budget = 40;
    while (rd_valid === 1'b1 && budget > 0) begin
      if (rd_ch === 2'd1) begin seen1++; val1 = int'(rd_value); end
      tick();
      budget--;
    end
    n_tests++; if (seen1 != 1 || val1 != 2) begin n_fail++; $display("FAIL coal_record ch1 records=%0d val=%0d exp 1 record val=2", seen1, val1); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL coal_drain count got %0d exp 0", count); end
    n_tests++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL coal_sticky dropped got %b exp 1", dropped); end
  endtask

  task automatic test_mask_clear();
    rd_ready = 1'b0;
    ch_mask = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      set_ch(1, ~ch_data[15:8]);
      tick();
    end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL mask_ch1 count got %0d exp 0", count); end
    ch_mask = 4'hF;
    set_ch(0, 8'h71); set_ch(2, 8'h72); set_ch(3, 8'h73);
    repeat (4) tick();
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL clear_pre count got %0d exp 3", count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL clear_count got %0d exp 0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %b exp 0", rd_valid); end
    n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL clear_dropped got %b exp 0", dropped); end
    tick();
    set_ch(2, 8'h99);
    tick();
    tick();
    n_tests++;
    if (rd_valid !== 1'b1 || rd_ch !== 2'd2 || rd_value !== 8'h99 || rd_time !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_next got v=%b ch=%0d val=%h t=%0d exp v=1 ch=2 val=99 t=0", rd_valid, rd_ch, rd_value, rd_time);
    end
  endtask

  task automatic test_back_to_back();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    set_ch(0, 8'hA1);
    tick();
    set_ch(0, 8'hA2);
    tick();
    tick();
    n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", count); end
    n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL b2b_dropped got %b exp 0", dropped); end
    n_tests++; if (rd_ch !== 2'd0 || rd_value !== 8'hA1) begin n_fail++; $display("FAIL b2b_first got ch=%0d val=%h exp ch=0 val=a1", rd_ch, rd_value); end
    rd_ready = 1'b1;
    tick();
    n_tests++; if (rd_ch !== 2'd0 || rd_value !== 8'hA2) begin n_fail++; $display("FAIL b2b_second got ch=%0d val=%h exp ch=0 val=a2", rd_ch, rd_value); end
    tick();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL b2b_drain count got %0d exp 0", count); end
  endtask

  task automatic test_async_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_ch(3, 8'(8'h60 + i));
      tick();
    end
    n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL areset_pre count got %0d exp 5", count); end
    #3;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b exp 0", rd_valid); end
    n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL areset_dropped got %b exp 0", dropped); end
    model_reset();
    #3;
    rst_n = 1'b1;
    tick();
    set_ch(0, 8'h3C);
    repeat (3) tick();
    n_tests++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_idle count=%0d v=%b exp 0 0", count, rd_valid); end
    enable = 1'b1;
    tick();
    set_ch(0, 8'h3D);
    tick();
    tick();
    n_tests++;
    if (rd_valid !== 1'b1 || rd_ch !== 2'd0 || rd_value !== 8'h3D || rd_time !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_rearm got v=%b ch=%0d val=%h t=%0d exp v=1 ch=0 val=3d t=0", rd_valid, rd_ch, rd_value, rd_time);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) ready_pct = $urandom_range(10, 90);
      rd_ready = ($urandom_range(0, 99) < ready_pct);
      enable = ($urandom_range(0, 99) >= 4);
      clear = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) ch_mask = 4'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) < 3) set_ch(c, 8'($urandom));
      end
      tick();
      n_tests++;
      if (int'(count) != m_q.size() || rd_valid !== (m_q.size() != 0) || dropped !== m_drop) begin
        n_fail++;
        $display("FAIL rand_status cyc=%0d got count=%0d v=%b drop=%b exp count=%0d drop=%b",
                 cyc, count, rd_valid, dropped, m_q.size(), m_drop);
      end
      if (m_q.size() != 0) begin
        n_tests++;
        if (int'(rd_ch) != m_q[0].ch || int'(rd_value) != m_q[0].val || int'(rd_time) != m_q[0].t) begin
          n_fail++;
          $display("FAIL rand_head cyc=%0d got ch=%0d val=%h t=%0d exp ch=%0d val=%h t=%0d",
                   cyc, rd_ch, rd_value, rd_time, m_q[0].ch, m_q[0].val, m_q[0].t);
        end
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arm_latency();
    test_simultaneous();
    test_coalesce();
    test_mask_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vpi_value_change_log.md
Name: vpi_value_change_log

Overview:
- Hardware value-change recorder. It watches NUM_CH input channels and logs every masked value change into a FIFO as a {channel, value, timestamp} record.
- It is the parametrised successor of the single-signal change-detect test block. Channel count, width, depth and timestamp width are generalised, and it adds per-channel masking, arming, coalescing and back-pressure.
- It sits in the VPI regression DUT. Records are drained through a valid/ready port so bench-side VPI value-change callbacks can be cross-checked against hardware.

Parameters:
- NUM_CH, 4, number of monitored channels (>=1).
- DATA_W, 8, width of each channel value.
- DEPTH, 16, FIFO entries; power of two, >=2.
- TS_W, 16, timestamp counter width.
- CH_W is derived as max(1,$clog2(NUM_CH)). CNT_W is derived as $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  logging enable; level.
- clear  in  1  synchronous clear pulse.
- ch_mask  in  NUM_CH  per-channel log enable.
- ch_data  in  NUM_CH*DATA_W  channel values; channel c occupies bits [c*DATA_W +: DATA_W].
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer accepts head.
- rd_ch  out  CH_W  head channel index.
- rd_value  out  DATA_W  head value.
- rd_time  out  TS_W  head timestamp.
- count  out  CNT_W  FIFO occupancy.
- dropped  out  1  sticky flag: a pending record was overwritten.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - all outputs to 0;
  - FIFO pointers, pending bits, prev/pending value registers and timestamp to 0;
  - the state machine to IDLE.
- States:
  - IDLE: enable=0. No detection, timestamp held.
  - ARM: entered on the first edge with enable=1 from IDLE. That edge loads prev[c]<=ch_data[c] for all c, generates no events and moves to RUN.
  - RUN: detection active, timestamp increments by 1 each edge and wraps at 2^TS_W.
  - Dropping enable to 0 returns to IDLE.
  - Pending records and FIFO contents are kept in every state and continue to drain.
- Detection, RUN only, edge k:
  - A change on channel c is ch_data[c]!=prev[c] with ch_mask[c]=1.
  - On a change: prev[c]<=ch_data[c], pend_val[c]<=ch_data[c], pend_time[c]<=ts (ts value before the increment), pending[c]<=1.
  - Unmasked channels still update prev[c] but generate no event.
- Coalescing:
  - If pending[c]=1 and is not being pushed this edge when a new change for c arrives, the pending value and time are overwritten and dropped<=1.
  - If pending[c] is pushed on the same edge a new change for c arrives, the new change re-sets pending[c] with the new value and no drop occurs.
- Push scheduler:
  - Each edge, the lowest-index pending channel is pushed if the FIFO is not full, or if it is full and a pop occurs that edge.
  - One push per cycle; pushing clears that pending bit.
  - FIFO full means pending records wait (back-pressure); there is no FIFO overflow.
- Latency: a change presented before edge k appears at the FIFO head (rd_valid=1) after edge k+1 when the FIFO was empty and no lower-index channel was pending.
- Read port:
  - First-word fall-through; rd_valid = count!=0.
  - Pop on rd_valid&&rd_ready. rd_ready with an empty FIFO is ignored.
  - rd_ch/rd_value/rd_time hold stable while rd_valid=1 and rd_ready=0.
- count: +1 on push only, -1 on pop only, unchanged on both. Range 0..DEPTH.
- clear (synchronous, highest priority after reset):
  - empties the FIFO, pending bits, dropped and the timestamp;
  - next state is ARM if enable=1, else IDLE.
  - Changes on the clear edge are not logged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are tracked by count.

Test Plan:
- Arm and latency: NUM_CH=4, DATA_W=8, ch_data=0x00000000.
  - enable=1 with ch_data=0x00000000 → no record on the arm edge.
  - After 3 RUN edges, ch1 changes 0x00→0x5A → after 2 edges rd_valid=1, rd_ch=1, rd_value=0x5A, rd_time=3.
- Simultaneous changes: ch0→0x11, ch2→0x22, ch3→0x33 on one edge with rd_ready=0 → records pop out in order ch0, ch2, ch3, each carrying the same rd_time; count peaks at 3.
- Coalesce: hold rd_ready=0 and fill the FIFO (DEPTH=16, count=16).
  - ch1→0x01 then ch1→0x02 → dropped=1.
  - After one pop, the next record pushed is ch1 value 0x02.
- Push with same-edge change: ch0 pending while being pushed, and ch0 changes again that edge → two consecutive ch0 records, dropped stays 0.
- Mask and clear: ch_mask=4'b1101, ch1 toggles → no record.
  - Pulse clear with 3 records queued → count=0, rd_valid=0, dropped=0, and the next record has rd_time=0.
- Async reset mid-drain: assert rst_n=0 mid-cycle with count=5 → count, rd_valid and dropped drop to 0 immediately.
  - After release, the block stays in IDLE until enable=1.
